// File: rtl/fact_inverse.sv
// fact_inverse: sequential inverse factorial.
// Finds the largest n with n! <= value and flags an exact match, doing one
// multiply step per clock under a start/busy/done handshake.
module fact_inverse #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [4:0]       n,
  output logic             exact
);

  localparam int PW = WIDTH + 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [4:0]       k_q, k_d;
  logic [4:0]       n_q, n_d;
  logic             exact_q, exact_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PW-1:0]    prod_s;
  logic             ovf_s;
  logic             accept_s;

  // Datapath: next running product p*(k+1) at full width, and its overflow flag.
  always_comb begin
    prod_s = PW'(p_q) * PW'(k_q + 5'd1);
    ovf_s  = |prod_s[PW-1:WIDTH];
  end

  // Next-state, datapath update and output-register logic.
  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    p_d      = p_q;
    k_d      = k_q;
    n_d      = n_q;
    exact_d  = exact_q;
    accept_s = start && (state_q != RUN);

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RUN;
          v_d     = value;
          p_d     = WIDTH'(1'b1);
          k_d     = 5'd1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // p always equals k! here; the checks run in priority order.
        if (p_q == v_q) begin
          state_d = DONE;
          n_d     = k_q;
          exact_d = 1'b1;
        end else if (p_q > v_q) begin
          state_d = DONE;
          n_d     = k_q - 5'd1;
          exact_d = 1'b0;
        end else if (ovf_s) begin
          // (k+1)! cannot be represented, so k! is the largest factorial <= v.
          state_d = DONE;
          n_d     = k_q;
          exact_d = 1'b0;
        end else begin
          state_d = RUN;
          p_d     = prod_s[WIDTH-1:0];
          k_d     = k_q + 5'd1;
        end
      end

      DONE: begin
        // The done cycle also accepts, so a held start re-launches at once.
        if (accept_s) begin
          state_d = RUN;
          v_d     = value;
          p_d     = WIDTH'(1'b1);
          k_d     = 5'd1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      p_q     <= WIDTH'(1'b1);
      k_q     <= 5'd1;
      n_q     <= 5'd0;
      exact_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      p_q     <= p_d;
      k_q     <= k_d;
      n_q     <= n_d;
      exact_q <= exact_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign n     = n_q;
  assign exact = exact_q;

endmodule

// File: tb/tb_fact_inverse.sv
// Testbench for fact_inverse: scoreboard driven by a behavioural model.
module tb_fact_inverse;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic [4:0]       n;
  logic             exact;

  fact_inverse #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .n     (n),
    .exact (exact)
  );

  typedef struct {
    int unsigned n;
    int unsigned ex;
    int          lat;
    int          acc;
    longint unsigned v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  logic done_prev = 1'b0;
  longint unsigned fact_tab[0:20];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: scan factorials with plain arithmetic.
  function automatic exp_t model(input longint unsigned v);
    exp_t e;
    longint unsigned f;
    int k;
    e.v = v;
    e.acc = 0;
    if (v == 0) begin
      e.n = 0; e.ex = 0; e.lat = 1;
    end else begin
      f = 1; k = 1;
      while (f * longint'(k + 1) <= v) begin
        f = f * longint'(k + 1);
        k++;
      end
      e.n  = k;
      e.ex = (f == v) ? 1 : 0;
      if (f == v) e.lat = k;
      else if (f * longint'(k + 1) >= (64'd1 << WIDTH)) e.lat = k;
      else e.lat = k + 1;
    end
    return e;
  endfunction

  // Acceptance observer: each accepted request pushes its expected result.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      sb.delete();
    end else if (start && !busy) begin
      e = model(longint'(value));
      e.acc = cyc;
      sb.push_back(e);
    end
  end

  // Monitor: compare results whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (done_prev) begin
          errors++; checks++;
          $display("FAIL done_pulse_width: got 2+ cycles, expected 1");
        end
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          chk($sformatf("n(v=%0d)", e.v), longint'(n), longint'(e.n));
          chk($sformatf("exact(v=%0d)", e.v), longint'(exact), longint'(e.ex));
          chk($sformatf("latency(v=%0d)", e.v), longint'(cyc - e.acc), longint'(e.lat));
          chk($sformatf("busy_cycles(v=%0d)", e.v), longint'(busy_cnt), longint'(e.lat));
          chk("busy_low_on_done", longint'(busy), 64'd0);
        end
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL timeout_%s: got no completion, expected done within 60 cycles", name);
      sb.delete();
    end
  endtask

  task automatic req(input logic [WIDTH-1:0] v);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = $urandom;
    wait_drain($sformatf("v%0d", v));
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    int sel;
    int j;
    fact_tab[0] = 1;
    for (int i = 1; i <= 20; i++) fact_tab[i] = fact_tab[i-1] * longint'(i);

    // Reset with start asserted.
    rst = 1'b1; start = 1'b1; value = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 64'd0);
    chk("rst_done", longint'(done), 64'd0);
    chk("rst_n", longint'(n), 64'd0);
    chk("rst_exact", longint'(exact), 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", longint'(busy), 64'd0);
    chk("idle_done", longint'(done), 64'd0);
    chk("idle_n", longint'(n), 64'd0);

    // Exact sweep, inexact, zero, upper range.
    req(32'd1); req(32'd2); req(32'd6); req(32'd24);
    req(32'd120); req(32'd720); req(32'd5040);
    req(32'd100); req(32'd0); req(32'd3);
    req(32'd479001600); req(32'hFFFFFFFF); req(32'd479001599);

    // start while busy is ignored.
    @(negedge clk);
    value = 32'd120; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    value = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore");
    chk("ignore_n_hold", longint'(n), 64'd5);

    // start held through DONE: back-to-back accepts.
    @(negedge clk);
    value = 32'd24; start = 1'b1;
    repeat (23) @(negedge clk);
    start = 1'b0;
    wait_drain("b2b");

    // Reset at E3 of a 5040 request.
    @(negedge clk);
    value = 32'd5040; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", longint'(busy), 64'd0);
    chk("midrst_done", longint'(done), 64'd0);
    chk("midrst_n", longint'(n), 64'd0);
    chk("midrst_exact", longint'(exact), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", longint'(done), 64'd0);
    req(32'd24);

    // Randomized requests.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: rv = $urandom;
        1: rv = $urandom_range(0, 1000);
        2: begin
          j = $urandom_range(1, 12);
          rv = WIDTH'(fact_tab[j] + longint'($urandom_range(0, 2)) - 64'd1);
        end
        default: rv = $urandom_range(0, 10000000);
      endcase
      req(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
